data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-port Data_Memory between two requesters: the CPU load/store path (single beats) and the VGA pixel fetch path (incrementing read bursts).
- Sits between CPU, Vga_Controller and data_mem.
- Issues at most one memory access per clk.
- VGA is favoured for real-time display; a starvation counter bounds CPU stall time.
- Read data is returned registered, one cycle after grant.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width
MAX_BURST, 16, maximum VGA burst length in beats
MAX_WAIT, 4, consecutive CPU-denied cycles before the CPU is forced a beat

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  combinational; CPU access issued this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  registered read-data valid
cpu_rdata  out  DW  registered read data
vga_req  in  1  burst start request, sampled in IDLE only
vga_addr  in  AW  burst base byte address
vga_len  in  $clog2(MAX_BURST)+1  beats requested
vga_gnt  out  1  combinational; VGA beat issued this cycle
vga_rvalid  out  1  registered beat valid
vga_rdata  out  DW  registered beat data
vga_done  out  1  one-cycle pulse with the last burst beat's rvalid
mem_we  out  1  to Data_Memory we
mem_a  out  AW  to Data_Memory a
mem_wd  out  DW  to Data_Memory wd
mem_rd  in  DW  from Data_Memory rd (combinational read)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; starve_cnt=0; beat_cnt=0; burst_addr=0.
  - cpu_rvalid=0, vga_rvalid=0, vga_done=0; cpu_rdata=0, vga_rdata=0.
  - Combinational outputs are 0 while in IDLE with no requests.
- FSM states: IDLE, VGA_BURST.
- IDLE:
  - vga_req=1 with vga_len clamped to 1..MAX_BURST (0 is treated as 1, >MAX_BURST as MAX_BURST):
    - Latch burst_addr=vga_addr and beat_cnt=clamped length.
    - Go to VGA_BURST. No VGA beat is issued in this cycle.
  - cpu_req in IDLE: grant the CPU in that same cycle (the CPU wins IDLE even if vga_req is also high).
- VGA_BURST, each cycle:
  - If cpu_req && starve_cnt==MAX_WAIT: grant the CPU; the burst pauses (burst_addr and beat_cnt hold).
  - Else: grant VGA at mem_a=burst_addr, mem_we=0; burst_addr+=4 (wraps modulo 2^AW); beat_cnt-=1.
  - When beat_cnt reaches 0 after a beat, return to IDLE next cycle.
- starve_cnt:
  - Increments each cycle with cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT.
  - Clears on cpu_gnt or when cpu_req=0.
- Worst-case CPU wait: MAX_WAIT+1 cycles.
- Mux outputs:
  - On cpu_gnt: mem_a=cpu_addr, mem_we=cpu_we, mem_wd=cpu_wdata.
  - Otherwise: mem_we=0 and mem_wd=0.
- Read return:
  - A granted read in cycle N gives x_rvalid=1 in cycle N+1, with x_rdata=mem_rd sampled at the cycle-N edge.
  - CPU writes produce no rvalid.
  - rdata holds its value when rvalid=0.
- vga_done: asserted together with the rvalid of the final beat.
- rst mid-burst: the burst is abandoned and no further rvalid or done is produced. The requester must re-issue.
- vga_req while in VGA_BURST: ignored.
- cpu_we=1 is never blocked by the burst beyond the starvation bound.

Optional Feature:
ARB_STATS_EN
- When defined, adds outputs stat_cpu_stall (32 bit) and stat_vga_beats (32 bit):
  - stat_cpu_stall counts cycles with cpu_stall=1.
  - stat_vga_beats counts VGA beats issued.
  - Both are saturating, cleared by rst, and otherwise free-running.
- When undefined, the ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=0x10, mem holds 0xDEADBEEF at 0x10 -> cpu_gnt in the same cycle, next cycle cpu_rvalid=1 and cpu_rdata=0xDEADBEEF, cpu_stall never asserted.
- VGA burst: vga_req, addr=0x100, len=4 -> IDLE→VGA_BURST, then mem_a=0x100,0x104,0x108,0x10C on consecutive cycles, 4 vga_rvalid pulses, vga_done with the 4th, then back in IDLE.
- Starvation: 16-beat burst with cpu_req raised at beat 2, MAX_WAIT=4 -> cpu_stall for 4 cycles, CPU granted on the 5th, burst resumes at the next address, total 16 VGA beats.
- CPU write during burst: forced CPU beat with we=1, wdata=0x55 -> mem_we=1 for one cycle, no cpu_rvalid, later read of that address returns 0x55.
- Length clamping: vga_len=0 gives 1 beat; vga_len=31 gives MAX_BURST=16 beats.
- Reset mid-burst: rst=1 after beat 3 of 8 -> next cycle state IDLE, no rvalid, no vga_done, all registered outputs 0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles every bus that meets at the data memory arbiter: the CPU
//   load/store path, the VGA burst fetch path and the single-port
//   Data_Memory side.
//
//   Modports:
//     slave  - the arbiter's view (requests and mem_rd in, grants,
//              read returns and memory controls out)
//     master - the environment's view (CPU, VGA controller and memory
//              model drive requests and mem_rd, observe everything else)
//
//   Parameters:
//     AW        byte address width
//     DW        data width
//     MAX_BURST longest VGA burst in beats (sets the vga_len width)
interface data_mem_arbiter_if #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
);
  localparam int LW = $clog2(MAX_BURST) + 1;

  // CPU single-beat load/store port
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  // VGA incrementing read-burst port
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [LW-1:0] vga_len;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          vga_done;

  // Data_Memory port
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  vga_req, vga_addr, vga_len,
    output vga_gnt, vga_rvalid, vga_rdata, vga_done,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output vga_req, vga_addr, vga_len,
    input  vga_gnt, vga_rvalid, vga_rdata, vga_done,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port Data_Memory between the CPU load/store path
//   (single beats) and the VGA pixel fetch path (incrementing read bursts).
//   At most one memory access is issued per clock. VGA is favoured while
//   a burst runs, but a starvation counter forces a CPU beat once the CPU
//   has been refused MAX_WAIT consecutive cycles, so the CPU never waits
//   more than MAX_WAIT+1 cycles. Grants are combinational; read data comes
//   back registered one cycle after the grant.
//
//   Ports:
//     clk            system clock
//     rst            synchronous active-high reset
//     bus            data_mem_arbiter_if.slave (CPU, VGA and memory buses)
//     stat_cpu_stall saturating count of cpu_stall cycles (ARB_STATS_EN only)
//     stat_vga_beats saturating count of VGA beats issued (ARB_STATS_EN only)
//
//   Optional build macro:
//     ARB_STATS_EN   adds the two statistics outputs; arbitration is the
//                    same with or without it.
module data_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         stat_cpu_stall,
  output logic [31:0]         stat_vga_beats
`endif
);

  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [0:0] {
    IDLE,
    VGA_BURST
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] burst_addr_q, burst_addr_d;

  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          vga_rvalid_q, vga_rvalid_d;
  logic [DW-1:0] vga_rdata_q, vga_rdata_d;
  logic          vga_done_q, vga_done_d;

  logic          cpu_gnt;
  logic          vga_gnt;
  logic [LW-1:0] len_clamped;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;

`ifdef ARB_STATS_EN
  logic [31:0]   stat_cpu_stall_q, stat_cpu_stall_d;
  logic [31:0]   stat_vga_beats_q, stat_vga_beats_d;
`endif

  // Requested burst length forced into 1..MAX_BURST so a zero length
  // still fetches one beat and an oversize request cannot overrun.
  always_comb begin
    len_clamped = bus.vga_len;
    if (bus.vga_len == '0) begin
      len_clamped = LW'(1);
    end else if (bus.vga_len > LW'(MAX_BURST)) begin
      len_clamped = LW'(MAX_BURST);
    end
  end

  // Arbitration and next-state logic. In IDLE the CPU is served at once
  // and a VGA request only latches the burst (its first beat comes next
  // cycle). During a burst VGA owns the memory unless the CPU has hit the
  // starvation limit, in which case the burst simply holds for a cycle.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    burst_addr_d = burst_addr_q;
    cpu_gnt      = 1'b0;
    vga_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_gnt = bus.cpu_req;
        if (bus.vga_req) begin
          state_d      = VGA_BURST;
          burst_addr_d = bus.vga_addr;
          beat_cnt_d   = len_clamped;
        end
      end
      VGA_BURST: begin
        if (bus.cpu_req && (starve_q == SW'(MAX_WAIT))) begin
          cpu_gnt = 1'b1;
        end else begin
          vga_gnt      = 1'b1;
          burst_addr_d = burst_addr_q + AW'(4);
          beat_cnt_d   = beat_cnt_q - LW'(1);
          if (beat_cnt_q == LW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Consecutive refused CPU cycles, saturating at the forcing threshold
    starve_d = starve_q;
    if (!bus.cpu_req || cpu_gnt) begin
      starve_d = '0;
    end else if (starve_q != SW'(MAX_WAIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Memory-side mux; an idle cycle drives all-zero controls so nothing
  // stray reaches the memory.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (cpu_gnt) begin
      mem_we = bus.cpu_we;
      mem_a  = bus.cpu_addr;
      mem_wd = bus.cpu_wdata;
    end else if (vga_gnt) begin
      mem_a  = burst_addr_q;
    end
  end

  // Read return: memory is read combinationally in the grant cycle and
  // captured here; rdata keeps its last value between valid pulses.
  always_comb begin
    cpu_rvalid_d = cpu_gnt && !bus.cpu_we;
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rd : cpu_rdata_q;
    vga_rvalid_d = vga_gnt;
    vga_rdata_d  = vga_gnt ? bus.mem_rd : vga_rdata_q;
    vga_done_d   = vga_gnt && (beat_cnt_q == LW'(1));
  end

`ifdef ARB_STATS_EN
  // Free-running event counters that stick at all-ones instead of wrapping
  always_comb begin
    stat_cpu_stall_d = stat_cpu_stall_q;
    stat_vga_beats_d = stat_vga_beats_q;
    if (bus.cpu_req && !cpu_gnt && (stat_cpu_stall_q != '1)) begin
      stat_cpu_stall_d = stat_cpu_stall_q + 32'd1;
    end
    if (vga_gnt && (stat_vga_beats_q != '1)) begin
      stat_vga_beats_d = stat_vga_beats_q + 32'd1;
    end
  end
`endif

  // All state and registered outputs; reset abandons any burst in flight
  // and suppresses the read return of the cycle it lands on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      starve_q         <= '0;
      beat_cnt_q       <= '0;
      burst_addr_q     <= '0;
      cpu_rvalid_q     <= 1'b0;
      cpu_rdata_q      <= '0;
      vga_rvalid_q     <= 1'b0;
      vga_rdata_q      <= '0;
      vga_done_q       <= 1'b0;
`ifdef ARB_STATS_EN
      stat_cpu_stall_q <= '0;
      stat_vga_beats_q <= '0;
`endif
    end else begin
      state_q          <= state_d;
      starve_q         <= starve_d;
      beat_cnt_q       <= beat_cnt_d;
      burst_addr_q     <= burst_addr_d;
      cpu_rvalid_q     <= cpu_rvalid_d;
      cpu_rdata_q      <= cpu_rdata_d;
      vga_rvalid_q     <= vga_rvalid_d;
      vga_rdata_q      <= vga_rdata_d;
      vga_done_q       <= vga_done_d;
`ifdef ARB_STATS_EN
      stat_cpu_stall_q <= stat_cpu_stall_d;
      stat_vga_beats_q <= stat_vga_beats_d;
`endif
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.vga_done   = vga_done_q;
  assign bus.mem_we     = mem_we;
  assign bus.mem_a      = mem_a;
  assign bus.mem_wd     = mem_wd;

`ifdef ARB_STATS_EN
  assign stat_cpu_stall = stat_cpu_stall_q;
  assign stat_vga_beats = stat_vga_beats_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Self-checking bench for data_mem_arbiter. A small word memory answers
//   mem_a combinationally with a fixed address pattern (0x10 holds
//   0xDEADBEEF) unless the word has been written. Expected read data is
//   queued when a request is driven and popped when rvalid shows up.
module tb_data_mem_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_BURST = 16;
  localparam int MAX_WAIT  = 4;

  logic clk = 1'b0;
  logic rst;

  int total;
  int bad;

  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] vga_q[$];

  logic [DW-1:0] wmem   [0:1023];
  logic          wvalid [0:1023];

  data_mem_arbiter_if #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] stat_cpu_stall;
  logic [31:0] stat_vga_beats;
`endif

  data_mem_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef ARB_STATS_EN
    ,
    .stat_cpu_stall(stat_cpu_stall),
    .stat_vga_beats(stat_vga_beats)
`endif
  );

  always #5 clk = ~clk;

  // Initial memory contents as a function of the byte address
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  // Memory model: written words override the pattern
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) wvalid[i] <= 1'b0;
    end else if (bus.mem_we) begin
      wmem[bus.mem_a[11:2]]   <= bus.mem_wd;
      wvalid[bus.mem_a[11:2]] <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_rd = pat(bus.mem_a);
    if (wvalid[bus.mem_a[11:2]] === 1'b1) bus.mem_rd = wmem[bus.mem_a[11:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.vga_len   = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total++;
    if ({bus.cpu_rvalid, bus.vga_rvalid, bus.vga_done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_valids got %b want 000",
               {bus.cpu_rvalid, bus.vga_rvalid, bus.vga_done});
    end
    total++;
    if (bus.cpu_rdata !== '0 || bus.vga_rdata !== '0) begin
      bad++;
      $display("[TB] FAIL reset_rdata got cpu=%h vga=%h want 0 0", bus.cpu_rdata, bus.vga_rdata);
    end
    total++;
    if ({bus.cpu_gnt, bus.vga_gnt, bus.cpu_stall, bus.mem_we} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_grants got %b want 0000",
               {bus.cpu_gnt, bus.vga_gnt, bus.cpu_stall, bus.mem_we});
    end
    total++;
    if (bus.mem_a !== '0 || bus.mem_wd !== '0) begin
      bad++;
      $display("[TB] FAIL reset_membus got a=%h wd=%h want 0 0", bus.mem_a, bus.mem_wd);
    end
  endtask

  task automatic test_cpu_read();
    logic [DW-1:0] exp;
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.mem_a !== 32'h10 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cpu_read_grant got gnt=%b stall=%b a=%h we=%b want 1 0 00000010 0",
               bus.cpu_gnt, bus.cpu_stall, bus.mem_a, bus.mem_we);
    end
    cpu_q.push_back(32'hDEADBEEF);
    tick();
    bus.cpu_req = 1'b0;
    exp = cpu_q.pop_front();
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp) begin
      bad++;
      $display("[TB] FAIL cpu_read_data got rvalid=%b rdata=%h want 1 %h",
               bus.cpu_rvalid, bus.cpu_rdata, exp);
    end
    tick();
    total++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL cpu_read_hold got rvalid=%b rdata=%h want 0 deadbeef",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  // Plain burst with no CPU traffic, followed by an IDLE check
  task automatic test_burst(input logic [AW-1:0] base, input int len,
                            input int nbeats, input string name);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp;
    int beats;
    int dones;
    tick();
    bus.vga_req  = 1'b1;
    bus.vga_addr = base;
    bus.vga_len  = 5'(len);
    #1;
    total++;
    if (bus.vga_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_start_beat got vga_gnt=%b want 0", name, bus.vga_gnt);
    end
    for (int i = 0; i < nbeats; i++) vga_q.push_back(pat(base + 32'(4 * i)));
    tick();
    bus.vga_req = 1'b0;
    exp_addr    = base;
    beats       = 0;
    dones       = 0;
    for (int cyc = 0; cyc < nbeats + 3; cyc++) begin
      if (bus.vga_rvalid === 1'b1) begin
        total++;
        if (vga_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL %s_extra_rvalid got rvalid=1 want 0", name);
        end else begin
          exp = vga_q.pop_front();
          if (bus.vga_rdata !== exp) begin
            bad++;
            $display("[TB] FAIL %s_rdata got %h want %h", name, bus.vga_rdata, exp);
          end
        end
      end
      if (bus.vga_done === 1'b1) begin
        dones++;
        total++;
        if (vga_q.size() != 0) begin
          bad++;
          $display("[TB] FAIL %s_done_early got beats_left=%0d want 0", name, vga_q.size());
        end
      end
      #1;
      if (bus.vga_gnt === 1'b1) begin
        beats++;
        total++;
        if (bus.mem_a !== exp_addr || bus.mem_we !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_addr got a=%h we=%b want %h 0", name, bus.mem_a, bus.mem_we, exp_addr);
        end
        exp_addr += 32'd4;
      end
      tick();
    end
    total++;
    if (beats != nbeats || dones != 1 || vga_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_count got beats=%0d done=%0d left=%0d want %0d 1 0",
               name, beats, dones, vga_q.size(), nbeats);
      vga_q.delete();
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h10;
    #1;
    total++;
    if (bus.cpu_gnt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_idle got cpu_gnt=%b want 1", name, bus.cpu_gnt);
    end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  // 16-beat burst with a CPU request raised after beat 2
  task automatic test_starve(input logic we, input logic [DW-1:0] wdata,
                             input logic [AW-1:0] caddr, input string name);
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp;
    logic          exp_g;
    logic          raised;
    int beats;
    int dones;
    int req_cyc;
    int we_cnt;
    tick();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 32'h200;
    bus.vga_len  = 5'd16;
    for (int i = 0; i < 16; i++) vga_q.push_back(pat(32'h200 + 32'(4 * i)));
    tick();
    bus.vga_req = 1'b0;
    exp_addr    = 32'h200;
    beats       = 0;
    dones       = 0;
    req_cyc     = 0;
    we_cnt      = 0;
    raised      = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus.vga_rvalid === 1'b1) begin
        total++;
        exp = (vga_q.size() != 0) ? vga_q.pop_front() : 'x;
        if (bus.vga_rdata !== exp) begin
          bad++;
          $display("[TB] FAIL %s_vga_rdata got %h want %h", name, bus.vga_rdata, exp);
        end
      end
      if (bus.vga_done === 1'b1) dones++;
      if (bus.cpu_rvalid === 1'b1) begin
        total++;
        exp = (cpu_q.size() != 0) ? cpu_q.pop_front() : 'x;
        if (bus.cpu_rdata !== exp) begin
          bad++;
          $display("[TB] FAIL %s_cpu_rdata got %h want %h", name, bus.cpu_rdata, exp);
        end
      end
      if (!raised && beats == 2) begin
        raised        = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = wdata;
        if (!we) cpu_q.push_back(pat(caddr));
      end
      #1;
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.cpu_req) begin
        exp_g = (req_cyc == MAX_WAIT);
        total++;
        if (bus.cpu_gnt !== exp_g || bus.cpu_stall !== !exp_g || bus.vga_gnt !== !exp_g) begin
          bad++;
          $display("[TB] FAIL %s_arb wait=%0d got gnt=%b stall=%b vga_gnt=%b want %b %b %b",
                   name, req_cyc, bus.cpu_gnt, bus.cpu_stall, bus.vga_gnt, exp_g, !exp_g, !exp_g);
        end
        if (exp_g) begin
          total++;
          if (bus.mem_a !== caddr || bus.mem_we !== we || bus.mem_wd !== wdata) begin
            bad++;
            $display("[TB] FAIL %s_cpu_bus got a=%h we=%b wd=%h want %h %b %h",
                     name, bus.mem_a, bus.mem_we, bus.mem_wd, caddr, we, wdata);
          end
        end
        req_cyc++;
      end
      if (bus.vga_gnt === 1'b1) begin
        beats++;
        total++;
        if (bus.mem_a !== exp_addr) begin
          bad++;
          $display("[TB] FAIL %s_vga_addr got %h want %h", name, bus.mem_a, exp_addr);
        end
        exp_addr += 32'd4;
      end
      tick();
      if (req_cyc == MAX_WAIT + 1) bus.cpu_req = 1'b0;
    end
    bus.cpu_req = 1'b0;
    total++;
    if (beats != 16 || dones != 1 || vga_q.size() != 0 || cpu_q.size() != 0 ||
        we_cnt != int'(we) || req_cyc != MAX_WAIT + 1) begin
      bad++;
      $display("[TB] FAIL %s_totals got beats=%0d done=%0d vq=%0d cq=%0d we=%0d waits=%0d want 16 1 0 0 %0d %0d",
               name, beats, dones, vga_q.size(), cpu_q.size(), we_cnt, req_cyc, int'(we), MAX_WAIT + 1);
      vga_q.delete();
      cpu_q.delete();
    end
  endtask

  task automatic test_cpu_write();
    test_starve(1'b1, 32'h55, 32'h300, "cpu_write");
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h300;
    tick();
    bus.cpu_req = 1'b0;
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h55) begin
      bad++;
      $display("[TB] FAIL write_readback got rvalid=%b rdata=%h want 1 00000055",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_clamp();
    test_burst(32'h500, 0, 1, "clamp_zero");
    test_burst(32'h600, 31, MAX_BURST, "clamp_max");
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] exp;
    int beats;
    int stray;
    tick();
    bus.vga_req  = 1'b1;
    bus.vga_addr = 32'h400;
    bus.vga_len  = 5'd8;
    for (int i = 0; i < 8; i++) vga_q.push_back(pat(32'h400 + 32'(4 * i)));
    tick();
    bus.vga_req = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 12 && beats < 3; cyc++) begin
      if (bus.vga_rvalid === 1'b1 && vga_q.size() != 0) void'(vga_q.pop_front());
      #1;
      if (bus.vga_gnt === 1'b1) beats++;
      tick();
    end
    total++;
    if (beats != 3) begin
      bad++;
      $display("[TB] FAIL rst_burst_progress got beats=%0d want 3", beats);
    end
    exp = vga_q.pop_front();
    total++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== exp) begin
      bad++;
      $display("[TB] FAIL rst_beat3 got rvalid=%b rdata=%h want 1 %h", bus.vga_rvalid, bus.vga_rdata, exp);
    end
    vga_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.cpu_rvalid, bus.vga_rvalid, bus.vga_done} !== 3'b000 ||
        bus.cpu_rdata !== '0 || bus.vga_rdata !== '0) begin
      bad++;
      $display("[TB] FAIL rst_regs got flags=%b cpu=%h vga=%h want 000 0 0",
               {bus.cpu_rvalid, bus.vga_rvalid, bus.vga_done}, bus.cpu_rdata, bus.vga_rdata);
    end
    #1;
    total++;
    if (bus.vga_gnt !== 1'b0 || bus.mem_a !== '0 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_idle got vga_gnt=%b a=%h we=%b want 0 0 0", bus.vga_gnt, bus.mem_a, bus.mem_we);
    end
    stray = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (bus.vga_rvalid !== 1'b0 || bus.vga_done !== 1'b0 || bus.vga_gnt !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("[TB] FAIL rst_abandon got stray_cycles=%0d want 0", stray);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cpu_read();
    test_burst(32'h100, 4, 4, "burst4");
    test_starve(1'b0, 32'h0, 32'h40, "starve");
    test_cpu_write();
    test_clamp();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
